mu0_mem_responder: RTL and testbench
====================================

// Module: mu0_mem_responder
// PURPOSE
//  Memory-side responder for the MU0 core bus: decodes addr/MEMrq/RnW, returns read data on
//  the shared tri-state 16-bit data bus and commits writes driven by the core.
//  Holds program/data RAM, with optional wait states and a side-band preload port for the bench.
//  Sits opposite mu0 on the board-level bus; the core drives data only for stores.
// PARAMETERS
//  DEPTH     4096  words implemented; addr >= DEPTH is out of range
//  WAIT_CYC  0     wait states; 0 = zero-latency mode, 1..15 = registered mode
// PORTS
//  clk       in     1   system clock, rising edge
//  rst       in     1   asynchronous reset, active high
//  addr      in     12  word address from core
//  data      inout  16  shared data bus; driven here only for reads
//  MEMrq     in     1   access request
//  RnW       in     1   1 = read, 0 = write
//  mem_rdy   out    1   access complete (registered mode); tied 1 in zero-latency mode
//  ld_valid  in     1   preload word valid
//  ld_addr   in     12  preload address
//  ld_data   in     16  preload data
//  ld_ready  out    1   preload word accepted this cycle
//  acc_err   out    1   one-cycle pulse: out-of-range access
// BEHAVIOUR
//  Reset, async: state=IDLE, cnt=0, mem_rdy=0 (registered mode), acc_err=0, data released to Z
//   immediately, pending write discarded. RAM contents not reset.
//  Bus drive: data = rd_word only when a read is being served, otherwise 16'hzzzz.
//  Zero-latency mode (WAIT_CYC=0):
//   - read: MEMrq=1 & RnW=1 -> data = mem[addr] combinationally, same cycle.
//   - write: MEMrq=1 & RnW=0 -> mem[addr] <= data at the rising edge.
//   - no FSM activity; mem_rdy constant 1.
//  Registered mode (WAIT_CYC=W>0), FSM IDLE -> WAIT -> ACCESS -> IDLE:
//   - IDLE: MEMrq=1 sampled at edge E0 -> latch addr_q, rnw_q; cnt <= W-1; go WAIT.
//   - WAIT: each edge, cnt==0 -> ACCESS, else cnt <= cnt-1.
//     ACCESS is the cycle after edge E0+W.
//   - ACCESS: mem_rdy=1, one cycle only.
//     Read: data = mem[addr_q] for the whole cycle.
//     Write: mem[addr_q] <= data at the closing edge. Always -> IDLE.
//   - Requester drops MEMrq in the cycle after mem_rdy.
//     MEMrq still high in IDLE is a new request.
//   - addr/RnW/MEMrq changes during WAIT/ACCESS are ignored (latched copies used).
//  Out of range (addr >= DEPTH):
//   - read returns 16'h0000; write ignored.
//   - acc_err pulses 1 cycle: after the sampling edge in zero-latency mode, with ACCESS in
//     registered mode.
//  Preload:
//   - ld_ready = ld_valid & MEMrq==0 & state==IDLE.
//   - On ld_ready, mem[ld_addr] <= ld_data at the edge; one word per cycle.
//   - Core request in the same cycle wins; ld_ready=0 and the word is held by the source.
//   - Out-of-range ld_addr: word dropped, acc_err pulses.
// TESTING
//  1 W=0: write 16'h1234 @12'h005, then read @12'h005 -> data=16'h1234 same cycle as MEMrq.
//  2 W=0: MEMrq=0, or MEMrq=1 & RnW=0 -> responder never drives data; bus reads Z with no
//    other driver.
//  3 W=2: read request sampled at E0 -> mem_rdy=1 and data valid only in the cycle after E0+2;
//    Z before and after.
//  4 W=2: write 16'hBEEF @12'h0FF, addr changed during WAIT -> 16'hBEEF lands @12'h0FF only.
//  5 Preload 4 words with MEMrq=0 -> ld_ready=1 each cycle, read-back matches.
//    ld_valid & MEMrq together -> ld_ready=0, core access served.
//  6 DEPTH=256, read @12'h100 -> data=16'h0000, acc_err 1-cycle pulse.
//    rst mid-WAIT -> IDLE, data Z at once, the write is never committed.

Source files
------------

// File: rtl/mu0_mem_responder.sv
// mu0_mem_responder: memory-side responder for the MU0 core bus.
// Holds a DEPTH-word RAM. It returns read data on the shared tri-state bus and
// commits the writes that the core drives. A side-band port preloads words.
//
// Parameters
//   DEPTH     words implemented; an addr >= DEPTH is out of range
//   WAIT_CYC  0 = zero-latency mode, 1..15 = registered mode with wait states
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   addr, MEMrq, RnW  core request: word address, request strobe, 1 = read
//   data              shared 16-bit bus; driven here only while a read is served
//   mem_rdy           access complete (registered mode), constant 1 in zero-latency mode
//   ld_valid/addr/data  preload word offered by the source
//   ld_ready          preload word accepted this cycle
//   acc_err           one-cycle pulse flagging an out-of-range access or preload
module mu0_mem_responder #(
    parameter  int unsigned DEPTH    = 4096,
    parameter  int unsigned WAIT_CYC = 0,
    localparam int unsigned AW       = 12,
    localparam int unsigned DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    inout  wire  [DW-1:0] data,
    input  logic          MEMrq,
    input  logic          RnW,
    output logic          mem_rdy,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          acc_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    // Signals that each mode's generate branch drives exactly once
    logic          idle;
    logic          drive;
    logic [DW-1:0] rd_word;
    logic          core_wr;
    logic [IW-1:0] core_idx;
    logic          core_err;

    logic          ld_hit;
    logic          ld_bad;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_word;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    // Tri-state return path: the bus is released whenever no read is being served
    assign data = drive ? rd_word : {DW{1'bz}};

    // The core owns the bus. Any request, or an access still in flight, blocks preload.
    assign ld_ready = ld_valid & ~MEMrq & idle;
    assign ld_hit   = ld_ready & in_range(ld_addr);
    assign ld_bad   = ld_ready & ~in_range(ld_addr);

    // Single RAM write port: a core store has priority over a preload word
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ld_addr[IW-1:0];
        wr_word = ld_data;
        if (core_wr) begin
            wr_en   = 1'b1;
            wr_idx  = core_idx;
            wr_word = data;
        end else if (ld_hit) begin
            wr_en   = 1'b1;
        end
    end

    // RAM contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
    end

    // Error pulse, registered off the access or preload that caused it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_err <= 1'b0;
        end else begin
            acc_err <= core_err | ld_bad;
        end
    end

    if (WAIT_CYC == 0) begin : g_zero_latency
        logic addr_ok;

        assign idle    = 1'b1;
        assign mem_rdy = 1'b1;

        // Reads are served combinationally. Reset releases the bus at once.
        always_comb begin
            addr_ok  = in_range(addr);
            drive    = MEMrq & RnW & ~rst;
            core_wr  = MEMrq & ~RnW & addr_ok & ~rst;
            core_idx = addr[IW-1:0];
            rd_word  = addr_ok ? mem[addr[IW-1:0]] : '0;
            core_err = MEMrq & ~addr_ok;
        end
    end else begin : g_registered
        localparam int unsigned CW = 4;
        localparam logic [1:0] S_IDLE   = 2'd0;
        localparam logic [1:0] S_WAIT   = 2'd1;
        localparam logic [1:0] S_ACCESS = 2'd2;

        logic [1:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [AW-1:0] addr_q, addr_d;
        logic          rnw_q, rnw_d;
        logic          rdy_q, rdy_d;
        logic          err_d;
        logic          access;
        logic          addr_q_ok;

        // State and latched-request registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                addr_q  <= '0;
                rnw_q   <= 1'b0;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                addr_q  <= addr_d;
                rnw_q   <= rnw_d;
                rdy_q   <= rdy_d;
            end
        end

        // Next state: the request is latched in IDLE, so later bus changes are ignored.
        // The counter starts at W-1, which places ACCESS in the cycle after edge E0+W.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            addr_d  = addr_q;
            rnw_d   = rnw_q;
            rdy_d   = 1'b0;
            err_d   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MEMrq) begin
                        addr_d  = addr;
                        rnw_d   = RnW;
                        cnt_d   = CW'(WAIT_CYC - 1);
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_ACCESS: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            // mem_rdy and acc_err are registered so that they coincide with ACCESS
            rdy_d = (state_d == S_ACCESS);
            err_d = (state_d == S_ACCESS) & ~in_range(addr_d);
        end

        assign mem_rdy   = rdy_q;
        assign idle      = (state_q == S_IDLE);
        assign access    = (state_q == S_ACCESS);
        assign addr_q_ok = in_range(addr_q);

        // Serve the latched access during the single ACCESS cycle
        always_comb begin
            drive    = access & rnw_q;
            core_wr  = access & ~rnw_q & addr_q_ok;
            core_idx = addr_q[IW-1:0];
            rd_word  = addr_q_ok ? mem[addr_q[IW-1:0]] : '0;
            core_err = err_d;
        end
    end

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Testbench for mu0_mem_responder. It drives one zero-latency instance and one
// registered-mode instance (WAIT_CYC=2), both with DEPTH=256.
// Where the responder must leave the bus released, the bench drives 16'h0000 onto it.
// A responder that wrongly drives the bus then shows up as a nonzero value.
module tb_mu0_mem_responder;

    localparam int unsigned DEP = 256;

    typedef struct {
        logic        rq;
        logic        rnw;
        logic [11:0] a;
        logic        drv;
        logic [15:0] bv;
        logic        lv;
        logic [11:0] la;
        logic [15:0] ld;
        logic        chk;
        logic [15:0] exp_d;
        logic        exp_lr;
        logic        exp_err;
    } zvec_t;

    logic clk = 1'b0;
    logic rst;

    logic [11:0] a0, la0;
    logic        rq0, rnw0, lv0, en0;
    logic [15:0] ld0, val0;
    wire  [15:0] bus0;
    logic        rdy0, lr0, err0;

    logic [11:0] a2, la2;
    logic        rq2, rnw2, lv2, en2;
    logic [15:0] ld2, val2;
    wire  [15:0] bus2;
    logic        rdy2, lr2, err2;

    int checks = 0;
    int errors = 0;
    int rn     = 0;

    logic [15:0] m0 [DEP];
    bit          v0 [DEP];
    logic [15:0] m2 [DEP];
    bit          v2 [DEP];

    zvec_t zt [16];

    assign bus0 = en0 ? val0 : 16'hzzzz;
    assign bus2 = en2 ? val2 : 16'hzzzz;

    always #5 clk = ~clk;

    mu0_mem_responder #(.DEPTH(DEP), .WAIT_CYC(0)) u0 (
        .clk(clk), .rst(rst), .addr(a0), .data(bus0), .MEMrq(rq0), .RnW(rnw0),
        .mem_rdy(rdy0), .ld_valid(lv0), .ld_addr(la0), .ld_data(ld0),
        .ld_ready(lr0), .acc_err(err0)
    );

    mu0_mem_responder #(.DEPTH(DEP), .WAIT_CYC(2)) u2 (
        .clk(clk), .rst(rst), .addr(a2), .data(bus2), .MEMrq(rq2), .RnW(rnw2),
        .mem_rdy(rdy2), .ld_valid(lv2), .ld_addr(la2), .ld_data(ld2),
        .ld_ready(lr2), .acc_err(err2)
    );

    task automatic chk16(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b", nm, idx, act, exp);
        end
    endtask

    function automatic zvec_t mkz(input logic rq, input logic rnw, input logic [11:0] a,
                                  input logic drv, input logic [15:0] bv, input logic lv,
                                  input logic [11:0] la, input logic [15:0] ld, input logic chk,
                                  input logic [15:0] exp_d, input logic exp_lr, input logic exp_err);
        zvec_t v;
        v.rq = rq; v.rnw = rnw; v.a = a; v.drv = drv; v.bv = bv; v.lv = lv; v.la = la;
        v.ld = ld; v.chk = chk; v.exp_d = exp_d; v.exp_lr = exp_lr; v.exp_err = exp_err;
        return v;
    endfunction

    // One zero-latency cycle: drive at posedge+1, sample the bus at negedge, sample acc_err after the edge
    task automatic apply_z(input zvec_t v, input string nm, input int idx);
        rq0 = v.rq; rnw0 = v.rnw; a0 = v.a; en0 = v.drv; val0 = v.bv;
        lv0 = v.lv; la0 = v.la; ld0 = v.ld;
        @(negedge clk);
        if (v.chk) chk16({nm, "_data"}, idx, bus0, v.exp_d);
        chk1({nm, "_ld_ready"}, idx, lr0, v.exp_lr);
        @(posedge clk); #1;
        chk1({nm, "_acc_err"}, idx, err0, v.exp_err);
    endtask

    // Random zero-latency traffic. The model applies the rules directly: a request is served,
    // otherwise a preload is accepted; an out-of-range address reads 0, drops the write and flags an error.
    task automatic run_zl_random(input int n);
        for (int i = 0; i < n; i++) begin
            zvec_t v;
            int    op;
            logic [11:0] a;
            logic [15:0] wd;
            op = int'($urandom_range(0, 3));
            a  = 12'($urandom_range(0, 319));
            wd = 16'($urandom);
            v  = mkz(1'b0, 1'b0, a, 1'b1, 16'h0000, 1'b0, 12'h000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
            case (op)
                1: begin
                    v.rq = 1'b1; v.rnw = 1'b1; v.drv = 1'b0;
                    if (32'(a) >= DEP) v.exp_err = 1'b1;
                    else begin v.chk = v0[a[7:0]]; v.exp_d = m0[a[7:0]]; end
                end
                2: begin
                    v.rq = 1'b1; v.rnw = 1'b0; v.bv = wd; v.exp_d = wd;
                    if (32'(a) >= DEP) v.exp_err = 1'b1;
                    else begin m0[a[7:0]] = wd; v0[a[7:0]] = 1'b1; end
                end
                3: begin
                    v.lv = 1'b1; v.la = a; v.ld = wd; v.exp_lr = 1'b1;
                    if (32'(a) >= DEP) v.exp_err = 1'b1;
                    else begin m0[a[7:0]] = wd; v0[a[7:0]] = 1'b1; end
                end
                default: ;
            endcase
            if ((op == 1 || op == 2) && $urandom_range(0, 1) == 1) begin
                v.lv = 1'b1; v.la = 12'($urandom_range(0, 319)); v.ld = 16'($urandom);
            end
            apply_z(v, "zl_rand", i);
        end
    endtask

    // One registered-mode access, cycle by cycle. The request cycle is c=-1 and edge E0 closes it.
    // mem_rdy and the read data belong to cycle c=2, the cycle after E0+2.
    // Address and RnW are scrambled and MEMrq is dropped during WAIT; a preload is held pending throughout.
    task automatic reg_access(input logic rnw, input logic [11:0] a, input logic [15:0] wd);
        logic        oor;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic [15:0] bv;
        int          id;
        id     = rn++;
        oor    = (32'(a) >= DEP);
        exp_rd = 16'h0000;
        chk_rd = 1'b1;
        if (!oor) begin
            exp_rd = m2[a[7:0]];
            chk_rd = v2[a[7:0]];
        end
        bv = rnw ? 16'h0000 : wd;
        if (!rnw && !oor) begin
            m2[a[7:0]] = wd;
            v2[a[7:0]] = 1'b1;
        end
        rq2 = 1'b1; rnw2 = rnw; a2 = a; lv2 = 1'b1; la2 = a; ld2 = 16'hDEAD; en2 = 1'b1; val2 = bv;
        @(negedge clk);
        chk1("rm_req_rdy", id, rdy2, 1'b0);
        chk1("rm_req_ldready", id, lr2, 1'b0);
        chk16("rm_req_bus", id, bus2, bv);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin a2 = a ^ 12'h0A5; rnw2 = ~rnw; end
            if (c == 1) rq2 = 1'b0;
            if (c == 2 && rnw) en2 = 1'b0;
            if (c == 3) begin lv2 = 1'b0; rnw2 = 1'b0; en2 = 1'b1; val2 = 16'h0000; end
            @(negedge clk);
            chk1("rm_rdy", id * 4 + c, rdy2, c == 2);
            chk1("rm_err", id * 4 + c, err2, oor && c == 2);
            chk1("rm_ldready", id * 4 + c, lr2, 1'b0);
            if (c == 2) begin
                if (rnw) begin
                    if (chk_rd) chk16("rm_rdata", id, bus2, exp_rd);
                end else begin
                    chk16("rm_wbus", id, bus2, wd);
                end
            end else begin
                chk16("rm_bus", id * 4 + c, bus2, (c == 3) ? 16'h0000 : bv);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [11:0] pa [6];
        logic [15:0] pd [6];
        pa = '{12'h040, 12'h041, 12'h042, 12'h043, 12'h05A, 12'h050};
        pd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5A5A, 16'h5050};

        rst = 1'b1;
        rq0 = 1'b0; rnw0 = 1'b0; a0 = '0; lv0 = 1'b0; la0 = '0; ld0 = '0; en0 = 1'b1; val0 = '0;
        rq2 = 1'b0; rnw2 = 1'b0; a2 = '0; lv2 = 1'b0; la2 = '0; ld2 = '0; en2 = 1'b1; val2 = '0;
        for (int i = 0; i < int'(DEP); i++) begin v0[i] = 1'b0; v2[i] = 1'b0; end

        // Reset state
        #12;
        chk1("rst_rdy_reg", 0, rdy2, 1'b0);
        chk1("rst_rdy_zl", 0, rdy0, 1'b1);
        chk1("rst_err_zl", 0, err0, 1'b0);
        chk1("rst_err_reg", 0, err2, 1'b0);
        chk16("rst_bus_reg", 0, bus2, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-latency table: rq rnw addr drv busval lv laddr ldata chk exp_data exp_ldready exp_err
        zt[0]  = mkz(0, 0, 12'h000, 1, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 0, 0);
        zt[1]  = mkz(0, 0, 12'h000, 1, 16'h0000, 1, 12'h000, 16'h0BAD, 1, 16'h0000, 1, 0);
        zt[2]  = mkz(0, 0, 12'h000, 1, 16'h0000, 1, 12'h0FF, 16'hC0DE, 1, 16'h0000, 1, 0);
        zt[3]  = mkz(1, 0, 12'h005, 1, 16'h1234, 0, 12'h000, 16'h0000, 1, 16'h1234, 0, 0);
        zt[4]  = mkz(1, 1, 12'h005, 0, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h1234, 0, 0);
        zt[5]  = mkz(0, 1, 12'h005, 1, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 0, 0);
        zt[6]  = mkz(1, 0, 12'h005, 1, 16'h4321, 0, 12'h000, 16'h0000, 1, 16'h4321, 0, 0);
        zt[7]  = mkz(1, 1, 12'h005, 0, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h4321, 0, 0);
        zt[8]  = mkz(1, 1, 12'h000, 0, 16'h0000, 1, 12'h005, 16'hFFFF, 1, 16'h0BAD, 0, 0);
        zt[9]  = mkz(1, 1, 12'h005, 0, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h4321, 0, 0);
        zt[10] = mkz(1, 1, 12'h100, 0, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 0, 1);
        zt[11] = mkz(0, 0, 12'h000, 1, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 0, 0);
        zt[12] = mkz(1, 0, 12'h100, 1, 16'h7777, 0, 12'h000, 16'h0000, 1, 16'h7777, 0, 1);
        zt[13] = mkz(1, 1, 12'h000, 0, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0BAD, 0, 0);
        zt[14] = mkz(0, 0, 12'h000, 1, 16'h0000, 1, 12'h1FF, 16'h1111, 1, 16'h0000, 1, 1);
        zt[15] = mkz(1, 1, 12'h0FF, 0, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'hC0DE, 0, 0);
        for (int i = 0; i < 16; i++) apply_z(zt[i], "zl_tab", i);

        run_zl_random(300);
        rq0 = 1'b0; lv0 = 1'b0; en0 = 1'b1; val0 = 16'h0000;

        // Registered mode: back-to-back preload with no core request
        for (int i = 0; i < 6; i++) begin
            lv2 = 1'b1; la2 = pa[i]; ld2 = pd[i];
            @(negedge clk);
            chk1("pre_ldready", i, lr2, 1'b1);
            @(posedge clk); #1;
            m2[pa[i][7:0]] = pd[i];
            v2[pa[i][7:0]] = 1'b1;
        end
        lv2 = 1'b0;

        // Read-back timing, write under address scramble, out-of-range accesses
        for (int i = 0; i < 6; i++) reg_access(1'b1, pa[i], 16'h0000);
        reg_access(1'b0, 12'h0FF, 16'hBEEF);
        reg_access(1'b1, 12'h0FF, 16'h0000);
        reg_access(1'b1, 12'h05A, 16'h0000);
        reg_access(1'b1, 12'h100, 16'h0000);
        reg_access(1'b0, 12'h120, 16'h9999);
        reg_access(1'b1, 12'h020, 16'h0000);

        // Reset in mid-WAIT abandons the pending write
        rq2 = 1'b1; rnw2 = 1'b0; a2 = 12'h050; en2 = 1'b1; val2 = 16'hDEAD;
        @(posedge clk); #1;
        rq2 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk1("rstwait_rdy", 0, rdy2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rstwait_rdy_after", i, rdy2, 1'b0);
            chk1("rstwait_err_after", i, err2, 1'b0);
            @(posedge clk); #1;
        end
        val2 = 16'h0000;
        reg_access(1'b1, 12'h050, 16'h0000);

        // Reset during a read ACCESS releases the bus at once
        rq2 = 1'b1; rnw2 = 1'b1; a2 = 12'h041; en2 = 1'b1; val2 = 16'h0000;
        @(posedge clk); #1;
        rq2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        en2 = 1'b0;
        @(negedge clk);
        chk16("rstacc_data", 0, bus2, m2[8'h41]);
        chk1("rstacc_rdy", 0, rdy2, 1'b1);
        #2;
        en2 = 1'b1; val2 = 16'h0000; rst = 1'b1;
        #1;
        chk16("rstacc_bus_released", 0, bus2, 16'h0000);
        chk1("rstacc_rdy_cleared", 0, rdy2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random registered-mode traffic against the model
        for (int i = 0; i < 40; i++) begin
            reg_access(1'($urandom_range(0, 1)), 12'($urandom_range(0, 319)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
